// File: rtl/rx_frame_controller.sv
// rx_frame_controller
// Turns the UART receiver byte stream into framed packets: SOF, LEN, LEN
// payload bytes, then an XOR checksum over LEN and the payload. A verified
// payload is replayed from an internal buffer over a valid/ready stream.
// Frame errors are reported as one-cycle pulses, and good frames are counted.
module rx_frame_controller #(
  parameter int         CLK_HZ        = 100000000,
  parameter int         BAUD          = 9600,
  parameter logic [7:0] SOF_BYTE      = 8'hA5,
  parameter int         MAX_LEN       = 16,
  parameter int         TIMEOUT_CHARS = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_state_i,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic       out_last_o,
  output logic       frame_ok_o,
  output logic       err_chk_o,
  output logic       err_len_o,
  output logic       err_to_o,
  output logic       err_ovr_o,
  output logic [7:0] frame_cnt_o,
  output logic       busy_o
);

  // One character is 10 bit times (start + 8 data + stop).
  localparam int TIMEOUT_CYC = (CLK_HZ / BAUD) * 10 * TIMEOUT_CHARS;
  localparam int TO_W        = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int IDX_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_PAYLOAD = 3'd2,
    S_CHK     = 3'd3,
    S_DRAIN   = 3'd4
  } state_t;

  // Running checksum step: XOR of LEN and every payload byte.
  function automatic logic [7:0] chk_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

  state_t          state_r, state_n;
  logic            tog_r;
  logic [TO_W-1:0] to_cnt_r, to_cnt_n;
  logic [7:0]      len_r, chk_r, wr_idx_r, rd_idx_r;
  logic [7:0]      buf_r [MAX_LEN];
  logic [7:0]      out_data_r, frame_cnt_r;
  logic            out_valid_r, out_last_r, busy_r;
  logic            frame_ok_r, err_chk_r, err_len_r, err_to_r, err_ovr_r;

  logic            ev_s, to_hit_s, accept_s, len_bad_s, last_wr_s, chk_match_s;
  logic [7:0]      rd_nxt_s;
  logic            ld_len_s, wr_byte_s, start_drain_s, adv_drain_s, end_drain_s;
  logic            ok_s, err_chk_s, err_len_s, err_to_s, err_ovr_s;

  // A byte event is any difference between the tracked toggle and the receiver status.
  assign ev_s        = (tog_r != rx_state_i);
  assign to_hit_s    = (to_cnt_r == TO_LAST);
  assign accept_s    = out_valid_r & out_ready_i;
  assign len_bad_s   = (rx_data_i == 8'd0) || (rx_data_i > MAX_LEN_B);
  assign last_wr_s   = (wr_idx_r == (len_r - 8'd1));
  assign chk_match_s = (rx_data_i == chk_r);
  assign rd_nxt_s    = rd_idx_r + 8'd1;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state decode; an event always takes priority over the timeout terminal count.
  always_comb begin
    state_n       = state_r;
    to_cnt_n      = {TO_W{1'b0}};
    ld_len_s      = 1'b0;
    wr_byte_s     = 1'b0;
    start_drain_s = 1'b0;
    adv_drain_s   = 1'b0;
    end_drain_s   = 1'b0;
    ok_s          = 1'b0;
    err_chk_s     = 1'b0;
    err_len_s     = 1'b0;
    err_to_s      = 1'b0;
    err_ovr_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (ev_s && (rx_data_i == SOF_BYTE)) begin
          state_n = S_LEN;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_LEN: begin
        if (ev_s) begin
          if (len_bad_s) begin
            err_len_s = 1'b1;
            state_n   = S_IDLE;
          end else begin
            ld_len_s = 1'b1;
            state_n  = S_PAYLOAD;
          end
        end else if (to_hit_s) begin
          err_to_s = 1'b1;
          state_n  = S_IDLE;
        end else begin
          to_cnt_n = to_cnt_r + TO_W'(1);
          state_n  = S_LEN;
        end
      end
      S_PAYLOAD: begin
        if (ev_s) begin
          wr_byte_s = 1'b1;
          if (last_wr_s) begin
            state_n = S_CHK;
          end else begin
            state_n = S_PAYLOAD;
          end
        end else if (to_hit_s) begin
          err_to_s = 1'b1;
          state_n  = S_IDLE;
        end else begin
          to_cnt_n = to_cnt_r + TO_W'(1);
          state_n  = S_PAYLOAD;
        end
      end
      S_CHK: begin
        if (ev_s) begin
          if (chk_match_s) begin
            ok_s          = 1'b1;
            start_drain_s = 1'b1;
            state_n       = S_DRAIN;
          end else begin
            err_chk_s = 1'b1;
            state_n   = S_IDLE;
          end
        end else if (to_hit_s) begin
          err_to_s = 1'b1;
          state_n  = S_IDLE;
        end else begin
          to_cnt_n = to_cnt_r + TO_W'(1);
          state_n  = S_CHK;
        end
      end
      S_DRAIN: begin
        // Bytes arriving while the buffer is being replayed are dropped.
        err_ovr_s = ev_s;
        if (accept_s) begin
          if (out_last_r) begin
            end_drain_s = 1'b1;
            state_n     = S_IDLE;
          end else begin
            adv_drain_s = 1'b1;
            state_n     = S_DRAIN;
          end
        end else begin
          state_n = S_DRAIN;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Toggle tracking, timeout counter, status pulses and busy flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tog_r      <= 1'b0;
      to_cnt_r   <= {TO_W{1'b0}};
      frame_ok_r <= 1'b0;
      err_chk_r  <= 1'b0;
      err_len_r  <= 1'b0;
      err_to_r   <= 1'b0;
      err_ovr_r  <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      tog_r      <= rx_state_i;
      to_cnt_r   <= to_cnt_n;
      frame_ok_r <= ok_s;
      err_chk_r  <= err_chk_s;
      err_len_r  <= err_len_s;
      err_to_r   <= err_to_s;
      err_ovr_r  <= err_ovr_s;
      busy_r     <= (state_n != S_IDLE);
    end
  end

  // Length capture, checksum accumulation and write pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_r    <= 8'd0;
      chk_r    <= 8'd0;
      wr_idx_r <= 8'd0;
    end else if (ld_len_s) begin
      len_r    <= rx_data_i;
      chk_r    <= rx_data_i;
      wr_idx_r <= 8'd0;
    end else if (wr_byte_s) begin
      chk_r    <= chk_fold(chk_r, rx_data_i);
      wr_idx_r <= wr_idx_r + 8'd1;
    end
  end

  // Payload buffer; contents are only meaningful between LEN and the end of DRAIN.
  always_ff @(posedge clk_i) begin
    if (wr_byte_s) begin
      buf_r[wr_idx_r[IDX_W-1:0]] <= rx_data_i;
    end
  end

  // Output stream registers and good-frame counter; data/last only move on acceptance.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_idx_r    <= 8'd0;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'd0;
      out_last_r  <= 1'b0;
      frame_cnt_r <= 8'd0;
    end else if (start_drain_s) begin
      rd_idx_r    <= 8'd0;
      out_valid_r <= 1'b1;
      out_data_r  <= buf_r[{IDX_W{1'b0}}];
      out_last_r  <= (len_r == 8'd1);
      frame_cnt_r <= frame_cnt_r + 8'd1;
    end else if (adv_drain_s) begin
      rd_idx_r    <= rd_nxt_s;
      out_data_r  <= buf_r[rd_nxt_s[IDX_W-1:0]];
      out_last_r  <= (rd_nxt_s == (len_r - 8'd1));
    end else if (end_drain_s) begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
    end
  end

  assign out_data_o  = out_data_r;
  assign out_valid_o = out_valid_r;
  assign out_last_o  = out_last_r;
  assign frame_ok_o  = frame_ok_r;
  assign err_chk_o   = err_chk_r;
  assign err_len_o   = err_len_r;
  assign err_to_o    = err_to_r;
  assign err_ovr_o   = err_ovr_r;
  assign frame_cnt_o = frame_cnt_r;
  assign busy_o      = busy_r;

endmodule

// File: tb/tb_rx_frame_controller.sv
// Bench for rx_frame_controller: directed frames from the test plan plus a
// randomized mix of good, corrupted, mis-sized and truncated frames. Expected
// results come from how each frame was built (payload list, XOR checksum,
// pulse counts, frame counter modulo 256).
module tb_rx_frame_controller;

  localparam int MAX_LEN = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_state = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] out_data, frame_cnt;
  logic       out_valid, out_last, frame_ok, err_chk, err_len, err_to, err_ovr, busy;

  rx_frame_controller #(
    .CLK_HZ(1000), .BAUD(100), .SOF_BYTE(8'hA5), .MAX_LEN(MAX_LEN), .TIMEOUT_CHARS(1)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_state_i(rx_state),
    .out_data_o(out_data), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_last_o(out_last), .frame_ok_o(frame_ok), .err_chk_o(err_chk),
    .err_len_o(err_len), .err_to_o(err_to), .err_ovr_o(err_ovr),
    .frame_cnt_o(frame_cnt), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int n_ok = 0, n_chk = 0, n_len = 0, n_to = 0, n_ovr = 0;
  int exp_ok = 0, exp_chk = 0, exp_len = 0, exp_to = 0, exp_ovr = 0, exp_cnt = 0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  logic [7:0] tx_q[$];
  int ready_mode = 0;  // 0: always ready, 1: random, 2: stalled
  logic hold_prev = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic hold_last = 1'b0;
  int seen, kind, flen, k;
  logic [7:0] g;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Stream monitor: counts pulses, drives ready, records accepted bytes, checks hold stability.
  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
      out_ready = 1'b1;
    end else begin
      if (frame_ok) n_ok++;
      if (err_chk) n_chk++;
      if (err_len) n_len++;
      if (err_to) n_to++;
      if (err_ovr) n_ovr++;
      check_eq("pulse_excl", 32'($countones({frame_ok, err_chk, err_len, err_to, err_ovr}) > 1), 32'd0);
      if (hold_prev) begin
        check_eq("hold_valid", 32'(out_valid), 32'd1);
        check_eq("hold_data", 32'(out_data), 32'(hold_data));
        check_eq("hold_last", 32'(out_last), 32'(hold_last));
      end
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_state = ~rx_state;
    @(posedge clk);
  endtask

  task automatic send_tx(input int max_gap);
    foreach (tx_q[i]) begin
      repeat ($urandom_range(0, max_gap)) @(posedge clk);
      send_byte(tx_q[i]);
    end
    tx_q.delete();
  endtask

  // kind 0: good frame (payload expected on the stream); kind 1: corrupted checksum.
  task automatic build_frame(input int len, input int fkind);
    logic [7:0] c, p;
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'(len));
    c = 8'(len);
    for (int i = 0; i < len; i++) begin
      p = 8'($urandom);
      tx_q.push_back(p);
      c ^= p;
      if (fkind == 0) exp_q.push_back({(i == len - 1), p});
    end
    if (fkind == 0) begin
      tx_q.push_back(c);
      exp_ok++;
      exp_cnt = (exp_cnt + 1) % 256;
    end else begin
      tx_q.push_back(c ^ 8'($urandom_range(1, 255)));
      exp_chk++;
    end
  endtask

  task automatic wait_idle(input string tag);
    int waited;
    logic idle;
    waited = 0;
    idle = 1'b0;
    while (!idle && waited < 3000) begin
      @(negedge clk);
      waited++;
      idle = !busy && !out_valid;
    end
    if (!idle) check_eq({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic settle(input string tag);
    wait_idle(tag);
    repeat (2) @(negedge clk);
    check_eq({tag, "_ok"}, n_ok, exp_ok);
    check_eq({tag, "_chk"}, n_chk, exp_chk);
    check_eq({tag, "_len"}, n_len, exp_len);
    check_eq({tag, "_to"}, n_to, exp_to);
    check_eq({tag, "_ovr"}, n_ovr, exp_ovr);
    check_eq({tag, "_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    check_eq({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check_eq({tag, "_byte"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_data", 32'(out_data), 32'd0);
    check_eq("rst_last", 32'(out_last), 32'd0);
    check_eq("rst_pulses", 32'({frame_ok, err_chk, err_len, err_to, err_ovr}), 32'd0);
    check_eq("rst_cnt", 32'(frame_cnt), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;

    // Directed good frame and first-byte latency.
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33};
    send_tx(0);
    send_byte(8'h03);
    @(negedge clk);
    check_eq("lat_ok", 32'(frame_ok), 32'd1);
    check_eq("lat_valid", 32'(out_valid), 32'd1);
    check_eq("lat_data", 32'(out_data), 32'h11);
    exp_q = '{9'h011, 9'h022, 9'h133};
    exp_ok++;
    exp_cnt = 1;
    settle("good");

    // Checksum error then a good frame.
    tx_q = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    exp_chk++;
    send_tx(2);
    settle("chkerr");
    build_frame(4, 0);
    send_tx(2);
    settle("after_chk");

    // Length errors, garbage before SOF, and the largest legal length.
    tx_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00};
    exp_len++;
    send_tx(1);
    settle("len0");
    tx_q = '{8'hA5, 8'h11};
    exp_len++;
    send_tx(1);
    settle("len17");
    build_frame(MAX_LEN, 0);
    send_tx(1);
    settle("maxlen");

    // Backpressure with an overrun byte during DRAIN.
    ready_mode = 2;
    tx_q = '{8'hA5, 8'h03, 8'hC1, 8'hC2, 8'hC3, 8'hC3};
    exp_q = '{9'h0C1, 9'h0C2, 9'h1C3};
    exp_ok++;
    exp_cnt = (exp_cnt + 1) % 256;
    send_tx(1);
    repeat (50) @(negedge clk);
    check_eq("bp_valid", 32'(out_valid), 32'd1);
    check_eq("bp_data", 32'(out_data), 32'hC1);
    check_eq("bp_last", 32'(out_last), 32'd0);
    send_byte(8'h77);
    exp_ovr++;
    repeat (3) @(negedge clk);
    check_eq("ovr_data", 32'(out_data), 32'hC1);
    check_eq("ovr_busy", 32'(busy), 32'd1);
    ready_mode = 1;
    settle("bp");
    ready_mode = 0;

    // Timeout exactly 100 cycles after the last byte edge.
    tx_q = '{8'hA5, 8'h02, 8'hAA};
    send_tx(0);
    seen = -1;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (err_to) begin
        seen = n;
        break;
      end
    end
    check_eq("to_latency", seen, 100);
    exp_to++;
    settle("to_pay");
    tx_q = '{8'hA5};
    exp_to++;
    send_tx(0);
    settle("to_len");

    // An event landing on the terminal count wins over the timeout.
    tx_q = '{8'hA5, 8'h02, 8'hAA};
    send_tx(0);
    repeat (99) @(posedge clk);
    send_byte(8'hBB);
    @(negedge clk);
    check_eq("term_no_to", 32'(err_to), 32'd0);
    check_eq("term_busy", 32'(busy), 32'd1);
    send_byte(8'h13);
    exp_q = '{9'h0AA, 9'h1BB};
    exp_ok++;
    exp_cnt = (exp_cnt + 1) % 256;
    settle("term");

    // Randomized frame mix.
    for (int it = 0; it < 40; it++) begin
      kind = $urandom_range(0, 4);
      ready_mode = $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < 3; j++) begin
          g = 8'($urandom);
          if (g == 8'hA5) g = 8'h5A;
          tx_q.push_back(g);
        end
      end
      flen = $urandom_range(1, MAX_LEN);
      case (kind)
        0, 1: build_frame(flen, 0);
        2: build_frame(flen, 1);
        3: begin
          tx_q.push_back(8'hA5);
          if ($urandom_range(0, 1) == 1) tx_q.push_back(8'h00);
          else tx_q.push_back(8'($urandom_range(MAX_LEN + 1, 255)));
          exp_len++;
        end
        default: begin
          tx_q.push_back(8'hA5);
          tx_q.push_back(8'(flen));
          k = $urandom_range(0, flen);
          for (int j = 0; j < k; j++) tx_q.push_back(8'($urandom));
          exp_to++;
        end
      endcase
      send_tx(4);
      settle("rnd");
    end
    ready_mode = 0;

    // Reset in the middle of a payload.
    tx_q = '{8'hA5, 8'h05, 8'h01, 8'h02};
    send_tx(0);
    @(negedge clk);
    rst = 1'b1;
    rx_state = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rstp_busy", 32'(busy), 32'd0);
    check_eq("rstp_valid", 32'(out_valid), 32'd0);
    check_eq("rstp_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    exp_cnt = 0;
    settle("rst_pay");

    // Reset in the middle of a stalled drain: nothing partial may come out.
    ready_mode = 2;
    build_frame(5, 0);
    exp_q.delete();
    send_tx(0);
    repeat (5) @(negedge clk);
    check_eq("rstd_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    rx_state = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rstd_valid", 32'(out_valid), 32'd0);
    check_eq("rstd_last", 32'(out_last), 32'd0);
    check_eq("rstd_data", 32'(out_data), 32'd0);
    check_eq("rstd_busy", 32'(busy), 32'd0);
    check_eq("rstd_cnt", 32'(frame_cnt), 32'd0);
    rst = 1'b0;
    exp_cnt = 0;
    ready_mode = 0;
    settle("rst_drain");

    // 256 good frames wrap the counter back to zero.
    for (int f = 0; f < 256; f++) begin
      build_frame(1, 0);
      send_tx(0);
      wait_idle("wrap");
      if (f == 254) begin
        @(negedge clk);
        check_eq("wrap_255", 32'(frame_cnt), 32'd255);
      end
    end
    settle("wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_controller.md
Name: rx_frame_controller

Overview:
Sequences the 8N1 UART receiver output into framed, checksum-verified packets for the downstream command logic. The controller watches the receiver's byte data bus and its toggle-per-byte status line, then hunts for a start-of-frame byte. It collects the length and payload, checks the XOR checksum, and only then releases the payload byte by byte over a valid/ready stream. It also reports frame errors and keeps a count of good frames.

Parameters:
CLK_HZ, 100000000, system clock frequency in Hz
BAUD, 9600, line baud rate; sets the inter-byte timeout
SOF_BYTE, 8'hA5, start-of-frame marker
MAX_LEN, 16, maximum payload length in bytes (1..255); also the payload buffer depth
TIMEOUT_CHARS, 4, inter-byte timeout in character times; TIMEOUT_CYC = (CLK_HZ/BAUD)*10*TIMEOUT_CHARS (default 416640)

Ports:
clk_i  in  1  system clock, all logic on rising edge
rst_i  in  1  asynchronous, active-high reset
rx_data_i  in  8  received byte from the UART receiver
rx_state_i  in  1  receiver status; toggles once per completed byte
out_data_o  out  8  payload byte
out_valid_o  out  1  out_data_o holds a payload byte
out_ready_i  in  1  consumer accepts a byte when out_valid_o and out_ready_i are both 1 on a rising edge
out_last_o  out  1  marks the final payload byte of a frame (qualified by out_valid_o)
frame_ok_o  out  1  one-cycle pulse when a frame's checksum matches
err_chk_o  out  1  one-cycle pulse on checksum mismatch
err_len_o  out  1  one-cycle pulse when the length byte is 0 or greater than MAX_LEN
err_to_o  out  1  one-cycle pulse on inter-byte timeout
err_ovr_o  out  1  one-cycle pulse when a byte arrives during DRAIN and is dropped
frame_cnt_o  out  8  number of good frames, wraps from 255 to 0
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Byte event: tog_q (reset 0) is compared with rx_state_i. An event occurs when they differ. The event is consumed at that rising edge, rx_data_i is sampled at the same edge, and tog_q is updated to rx_state_i. Same clock domain, so there is no synchronizer.
- Frame format: SOF, LEN, LEN payload bytes, CHK. CHK = LEN XOR all payload bytes.
- Reset values: state=IDLE, all outputs 0, frame_cnt_o=0, counters 0. Buffer contents are don't-care.
- Reset mid-frame or mid-drain aborts immediately. No error pulse is generated and no partial payload is emitted.
- IDLE: on an event, a byte equal to SOF_BYTE moves to LEN; any other byte is ignored.
- LEN: on an event, a byte of 0 or greater than MAX_LEN pulses err_len_o and returns to IDLE. Otherwise len_q=byte, chk_q=byte, wr_idx=0, and the state moves to PAYLOAD.
- PAYLOAD: on an event, buf[wr_idx]=byte, chk_q ^= byte, wr_idx++. The state moves to CHK when the byte just written is index len_q-1.
- CHK: on an event, a match with chk_q pulses frame_ok_o, increments frame_cnt_o, sets rd_idx=0 and moves to DRAIN. A mismatch pulses err_chk_o and returns to IDLE.
- DRAIN:
  - out_valid_o=1, out_data_o=buf[rd_idx], out_last_o=(rd_idx==len_q-1).
  - Each valid&ready edge increments rd_idx.
  - Acceptance of the last byte returns to IDLE; out_valid_o is 0 in the next cycle.
  - out_data_o and out_last_o must stay stable while valid is high and ready is low.
- Latency: out_valid_o rises in the cycle after the CHK-byte edge, the same cycle frame_ok_o is high.
- Bytes arriving in DRAIN are dropped and pulse err_ovr_o. The state is unaffected, and the receiver toggle is still tracked.
- Timeout:
  - to_cnt clears on every event and on entry to IDLE.
  - It counts while in LEN, PAYLOAD or CHK.
  - On reaching TIMEOUT_CYC-1 it pulses err_to_o and returns to IDLE.
  - If an event and the timeout terminal count fall on the same edge, the event wins and there is no timeout.
- No timeout applies in IDLE or DRAIN; DRAIN waits indefinitely for the consumer.
- Error pulses are mutually exclusive per cycle; at most one fires per event.

Test Plan:
- Good frame: A5 03 11 22 33 03 with ready=1 -> frame_ok_o pulse, stream 11,22,33 with last on 33, frame_cnt_o=1, busy_o drops after 33.
- Checksum error: A5 02 10 20 00 -> err_chk_o pulse, no out_valid_o, frame_cnt_o unchanged; a following good frame is accepted.
- Length errors: A5 00 -> err_len_o; A5 11 with MAX_LEN=16 -> err_len_o; garbage 00 FF 5A before A5 is ignored.
- Backpressure plus overrun: good 3-byte frame with ready=0 for 50 cycles -> data held stable, out_last_o=0 until index 2; a byte injected during DRAIN -> err_ovr_o, payload unchanged.
- Timeout (CLK_HZ=1000, BAUD=100, TIMEOUT_CHARS=1, so 100 cycles): A5 02 AA then silence -> err_to_o exactly 100 cycles after AA's edge; an event on the terminal cycle -> no timeout.
- Reset mid-PAYLOAD and mid-DRAIN -> outputs zero, state IDLE, frame_cnt_o=0; 256 good frames -> frame_cnt_o wraps to 0.
